// File: rtl/ht_fifo_rd_pkg.sv
// ht_fifo_rd_pkg: shared width helper for the ht FIFO read stream
package ht_fifo_rd_pkg;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/ht_reg_fifo.sv
// ht_reg_fifo: small circular register FIFO with non-power-of-2 depth support
module ht_reg_fifo import ht_fifo_rd_pkg::*; #(
  parameter int DATA_W = 10,
  parameter int BUF_DEPTH = 4,
  localparam int CW = cnt_w(BUF_DEPTH),
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     cnt
);
  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr <= inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= inc(rd_ptr);
      cnt <= cnt + CW'(wr_en) - CW'(rd_en);
    end
  end
endmodule

// File: rtl/ht_fifo_rd_stream.sv
// ht_fifo_rd_stream: credit-based reader turning a fixed-latency FIFO read port into a valid/ready stream
module ht_fifo_rd_stream import ht_fifo_rd_pkg::*; #(
  parameter int DATA_W = 10,
  parameter int RD_LAT = 1,
  parameter int BUF_DEPTH = 4,
  localparam int CW = cnt_w(BUF_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_req_o,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CW-1:0]     buf_cnt_o
);
  if (RD_LAT < 1 || RD_LAT > 4 || BUF_DEPTH < RD_LAT + 1) begin : g_bad_cfg
    $error("ht_fifo_rd_stream: RD_LAT must be 1..4 and BUF_DEPTH >= RD_LAT+1");
  end
  logic [RD_LAT-1:0] sr;
  logic pop, cap;
  assign pop = valid_o & ready_i;
  assign cap = sr[RD_LAT-1];
  assign valid_o = buf_cnt_o != '0;
  always_comb fifo_rd_req_o = !fifo_empty_i && ($countones(sr) + int'(buf_cnt_o) - int'(pop) < BUF_DEPTH);
  always_ff @(posedge clk_i) sr <= rst_i ? '0 : RD_LAT'({sr, fifo_rd_req_o});
  ht_reg_fifo #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .wr_en(cap),
    .wr_data(fifo_rd_data_i),
    .rd_en(pop),
    .rd_data(data_o),
    .cnt(buf_cnt_o)
  );
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i) buf_cnt_o <= CW'(BUF_DEPTH));
  a_no_ovf: assert property (@(posedge clk_i) disable iff (rst_i) !(cap && buf_cnt_o == CW'(BUF_DEPTH) && !pop));
  a_stable: assert property (@(posedge clk_i) disable iff (rst_i) valid_o && !ready_i |=> valid_o && $stable(data_o));
endmodule

// File: tb/tb_ht_fifo_rd_stream.sv
// tb_ht_fifo_rd_stream: scoreboard bench over two latency/depth configurations
module tb_ht_fifo_rd_stream;
  localparam int W = 10;
  logic clk = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  task automatic chk(input int id, input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s got %0h exp %0h", id, tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int RL = g ? 2 : 1;
    localparam int BD = g ? 3 : 4;
    localparam int E = 8;
    logic rst = 1, rdy = 0, fin = 0;
    logic req, empty, valid;
    logic [RL-1:0][W-1:0] pipe;
    logic [W-1:0] data;
    logic [$clog2(BD+1)-1:0] bcnt;
    logic [W-1:0] mem [1024];
    logic [W-1:0] sb [$];
    int wr_n = 0, rd_n = 0;
    assign empty = wr_n == rd_n;
    ht_fifo_rd_stream #(.DATA_W(W), .RD_LAT(RL), .BUF_DEPTH(BD)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .fifo_empty_i(empty),
      .fifo_rd_req_o(req),
      .fifo_rd_data_i(pipe[RL-1]),
      .data_o(data),
      .valid_o(valid),
      .ready_i(rdy),
      .buf_cnt_o(bcnt)
    );
    always @(posedge clk) begin
      if (rst) begin
        rd_n <= wr_n;
        pipe <= '0;
      end else begin
        pipe <= (RL*W)'({pipe, req ? mem[rd_n] : W'(0)});
        if (req) rd_n <= rd_n + 1;
      end
    end
    always @(negedge clk) begin
      if (!rst) begin
        chk(g, "cnt_bound", 32'(bcnt <= BD), 1);
        if (req) chk(g, "req_when_empty", 32'(empty), 0);
        if (valid && rdy) begin
          chk(g, "word_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) chk(g, "order", 32'(data), 32'(sb.pop_front()));
        end
      end
    end
    task automatic cyc;
      @(posedge clk);
      #1;
    endtask
    task automatic push(input logic [W-1:0] w);
      mem[wr_n] = w;
      sb.push_back(w);
      wr_n++;
    endtask
    task automatic start;
      rst = 1;
      cyc;
      sb.delete();
      rst = 0;
    endtask
    task automatic drain(input string tag, input bit rnd);
      int n = 0;
      while (sb.size() != 0 && n < 3000) begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc;
        n++;
      end
      chk(g, tag, sb.size(), 0);
      rdy = 0;
    endtask
    initial begin
      int nreq;
      rdy = 1;
      start;
      for (int i = 1; i <= 8; i++) push(W'(i));
      for (int c = 0; c <= RL + 9; c++) begin
        @(negedge clk);
        if (c == 0) begin
          chk(g, "rst_cnt", 32'(bcnt), 0);
          chk(g, "rst_data", 32'(data), 0);
          chk(g, "t1_req_c0", 32'(req), 1);
        end
        if (c <= RL) chk(g, "t1_valid_early", 32'(valid), 0);
        else if (c <= RL + 8) begin
          chk(g, "t1_valid", 32'(valid), 1);
          chk(g, "t1_data", 32'(data), c - RL);
        end else chk(g, "t1_valid_end", 32'(valid), 0);
        cyc;
      end
      rdy = 0;
      start;
      for (int i = 1; i <= 10; i++) push(W'(i));
      nreq = 0;
      for (int c = 0; c <= RL + BD + 6; c++) begin
        @(negedge clk);
        if (req) nreq++;
        if (valid) chk(g, "t2_hold_data", 32'(data), 1);
        cyc;
      end
      @(negedge clk);
      chk(g, "t2_nreq", nreq, BD);
      chk(g, "t2_cnt", 32'(bcnt), BD);
      chk(g, "t2_req_off", 32'(req), 0);
      chk(g, "t2_valid", 32'(valid), 1);
      cyc;
      drain("t2_drain", 0);
      start;
      for (int i = 0; i < 200; i++) push(W'($urandom_range(0, 1023)));
      drain("t3_drain", 1);
      rdy = 1;
      start;
      for (int i = 1; i <= 3; i++) push(W'('h100 + i));
      for (int c = 0; c <= E + RL + 3; c++) begin
        if (c == E) begin
          push(W'('h104));
          push(W'('h105));
        end
        @(negedge clk);
        if (c >= 3 && c < E) chk(g, "t4_no_req", 32'(req), 0);
        if (c == RL + 3) chk(g, "t4_third", 32'(data), 'h103);
        if (c == RL + 4 || c == E + RL || c == E + RL + 3) chk(g, "t4_gap_valid", 32'(valid), 0);
        if (c == E + RL + 1) begin
          chk(g, "t4_fourth_valid", 32'(valid), 1);
          chk(g, "t4_fourth", 32'(data), 'h104);
        end
        if (c == E + RL + 2) chk(g, "t4_fifth", 32'(data), 'h105);
        cyc;
      end
      chk(g, "t4_sb", sb.size(), 0);
      rdy = 0;
      start;
      for (int i = 1; i <= 3; i++) push(W'('h200 + i));
      for (int c = 0; c <= RL + 2; c++) begin
        @(negedge clk);
        if (c == RL + 2) begin
          chk(g, "t5_pre_cnt", 32'(bcnt), 2);
          rst = 1;
        end
        cyc;
      end
      rst = 0;
      sb.delete();
      @(negedge clk);
      chk(g, "t5_valid", 32'(valid), 0);
      chk(g, "t5_cnt", 32'(bcnt), 0);
      chk(g, "t5_data", 32'(data), 0);
      cyc;
      @(negedge clk);
      chk(g, "t5_no_capture", 32'(bcnt), 0);
      cyc;
      for (int i = 4; i <= 6; i++) push(W'('h200 + i));
      drain("t5_drain", 0);
      start;
      for (int i = 0; i < 3 * BD; i++) push(W'('h300 + i));
      for (int c = 0; c < BD + RL + 2; c++) cyc;
      @(negedge clk);
      chk(g, "t6_full", 32'(bcnt), BD);
      cyc;
      rdy = 1;
      for (int n = 0; sb.size() != 0 && n < 200; n++) begin
        @(negedge clk);
        chk(g, "t6_stream_valid", 32'(valid), 1);
        cyc;
      end
      chk(g, "t6_sb", sb.size(), 0);
      rdy = 0;
      fin = 1;
    end
  end
  initial begin
    for (int i = 0; i < 60000 && !(cfg[0].fin && cfg[1].fin); i++) @(posedge clk);
    chk(0, "finish", 32'(cfg[0].fin && cfg[1].fin), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
